dynamic_input_port_rx: RTL and testbench

- Receive end of the credit-based (valid/yummy) dynamic network link; one instance per router input direction.
- Buffers incoming flits and returns one yummy credit per dequeued flit.
- Decodes each packet header with dimension-ordered (X then Y) routing and drives per-output route requests and tail to the output ports.
- Consumes their per-input thanks signals.

---
 rtl/dynamic_input_port_rx_pkg.sv | 26 ++
 rtl/dynamic_rx_flit_fifo.sv | 38 +++
 rtl/dynamic_input_port_rx.sv | 78 +++++++
 tb/tb_dynamic_input_port_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dynamic_input_port_rx_pkg.sv
// dynamic_input_port_rx_pkg: network widths, header field offsets, direction and state encodings
package dynamic_input_port_rx_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int CHIP_ID_WIDTH = 14;
  localparam int XY_WIDTH = 8;
  localparam int PAYLOAD_LEN = 8;
  localparam int CHIP_HI = DATA_WIDTH - 1;
  localparam int X_HI = CHIP_HI - CHIP_ID_WIDTH;
  localparam int Y_HI = X_HI - XY_WIDTH;
  localparam int LEN_HI = DATA_WIDTH - CHIP_ID_WIDTH - 2 * XY_WIDTH - 4;
  localparam int LEN_LO = DATA_WIDTH - CHIP_ID_WIDTH - 2 * XY_WIDTH - 3 - PAYLOAD_LEN;
  localparam logic [4:0] DIR_N = 5'b00001;
  localparam logic [4:0] DIR_E = 5'b00010;
  localparam logic [4:0] DIR_S = 5'b00100;
  localparam logic [4:0] DIR_W = 5'b01000;
  localparam logic [4:0] DIR_P = 5'b10000;
  typedef enum logic {HEADER, BODY} state_t;
  // Off-chip packets head for the (0,0) gateway tile, X resolved before Y
  function automatic logic [4:0] xy_route(input logic chip_match,
                                          input logic [XY_WIDTH-1:0] dx, dy, mx, my);
    logic [XY_WIDTH-1:0] ex, ey;
    ex = chip_match ? dx : '0;
    ey = chip_match ? dy : '0;
    return ex > mx ? DIR_E : ex < mx ? DIR_W : ey > my ? DIR_S : ey < my ? DIR_N : DIR_P;
  endfunction
endpackage

// File: rtl/dynamic_rx_flit_fifo.sv
// dynamic_rx_flit_fifo: flit buffer; push while full is accepted only alongside a pop
module dynamic_rx_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (PTR_W+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push = i_wr & (~o_full | i_rd);
  assign w_pop = i_rd & ~o_empty;
  assign o_rd_data = r_mem[r_rptr];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end
endmodule

// File: rtl/dynamic_input_port_rx.sv
// dynamic_input_port_rx: credit-based link receiver with XY route decode and packet tracking
module dynamic_input_port_rx
  import dynamic_input_port_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_PTR_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHIP_ID_WIDTH-1:0] my_chip_id_in,
  input  logic [XY_WIDTH-1:0]      my_loc_x_in,
  input  logic [XY_WIDTH-1:0]      my_loc_y_in,
  input  logic                     valid_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     yummy_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  output logic                     route_req_n_out,
  output logic                     route_req_e_out,
  output logic                     route_req_s_out,
  output logic                     route_req_w_out,
  output logic                     route_req_p_out,
  output logic                     tail_out,
  input  logic                     thanks_n_in,
  input  logic                     thanks_e_in,
  input  logic                     thanks_s_in,
  input  logic                     thanks_w_in,
  input  logic                     thanks_p_in,
  output logic                     protocol_err_out
);
  state_t r_state, w_next;
  logic [PAYLOAD_LEN-1:0] r_cnt, w_len;
  logic [4:0] r_route, w_route, w_rr, w_thanks;
  logic r_yummy, r_err, w_full, w_empty, w_deq, w_drop;
  dynamic_rx_flit_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(FIFO_PTR_W), .W(DATA_WIDTH)) u_fifo (
    .clk(clk), .reset(reset), .i_wr(valid_in), .i_wr_data(data_in), .i_rd(w_deq),
    .o_rd_data(data_out), .o_full(w_full), .o_empty(w_empty)
  );
  assign valid_out = ~w_empty;
  assign w_thanks = {thanks_p_in, thanks_w_in, thanks_s_in, thanks_e_in, thanks_n_in};
  assign w_deq = valid_out & |w_thanks;
  assign w_drop = valid_in & w_full & ~w_deq;
  assign w_len = data_out[LEN_HI:LEN_LO];
  assign w_route = xy_route(data_out[CHIP_HI -: CHIP_ID_WIDTH] == my_chip_id_in,
                            data_out[X_HI -: XY_WIDTH], data_out[Y_HI -: XY_WIDTH],
                            my_loc_x_in, my_loc_y_in);
  always_ff @(posedge clk)
    r_state <= reset ? HEADER : w_next;
  always_comb
    w_next = !w_deq ? r_state :
             r_state == HEADER ? (w_len != '0 ? BODY : HEADER) :
             r_cnt == PAYLOAD_LEN'(1) ? HEADER : BODY;
  always_comb begin
    w_rr = !valid_out ? 5'b0 : r_state == HEADER ? w_route : r_route;
    tail_out = valid_out & (r_state == HEADER ? w_len == '0 : r_cnt == PAYLOAD_LEN'(1));
  end
  assign {route_req_p_out, route_req_w_out, route_req_s_out, route_req_e_out, route_req_n_out} = w_rr;
  assign yummy_out = r_yummy;
  assign protocol_err_out = r_err;
  // Any thanks not matching the live request (including while empty) is a protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_route <= '0;
      r_yummy <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_yummy <= w_deq;
      r_err <= r_err | w_drop | (|(w_thanks & ~w_rr));
      if (w_deq && r_state == HEADER) begin
        r_cnt <= w_len;
        r_route <= w_route;
      end else if (w_deq) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dynamic_input_port_rx.sv
// tb_dynamic_input_port_rx: directed vectors for routing, credits, overflow and reset
module tb_dynamic_input_port_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [13:0] my_chip_id_in = 14'd3;
  logic [7:0] my_loc_x_in = 8'd4, my_loc_y_in = 8'd4;
  logic valid_in = 1'b0;
  logic [63:0] data_in = '0;
  logic yummy_out, valid_out, tail_out, protocol_err_out;
  logic [63:0] data_out;
  logic rn, re, rs, rw, rp;
  logic thanks_n_in = 1'b0, thanks_e_in = 1'b0, thanks_s_in = 1'b0, thanks_w_in = 1'b0, thanks_p_in = 1'b0;
  int n_cmp = 0, n_bad = 0;
  wire [4:0] rr = {rp, rw, rs, re, rn};

  dynamic_input_port_rx dut (
    .clk(clk), .reset(reset), .my_chip_id_in(my_chip_id_in), .my_loc_x_in(my_loc_x_in),
    .my_loc_y_in(my_loc_y_in), .valid_in(valid_in), .data_in(data_in), .yummy_out(yummy_out),
    .data_out(data_out), .valid_out(valid_out), .route_req_n_out(rn), .route_req_e_out(re),
    .route_req_s_out(rs), .route_req_w_out(rw), .route_req_p_out(rp), .tail_out(tail_out),
    .thanks_n_in(thanks_n_in), .thanks_e_in(thanks_e_in), .thanks_s_in(thanks_s_in),
    .thanks_w_in(thanks_w_in), .thanks_p_in(thanks_p_in), .protocol_err_out(protocol_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [63:0] d);
    valid_in = 1'b1;
    data_in = d;
    step();
    valid_in = 1'b0;
  endtask

  function automatic logic [63:0] hdr(input logic [13:0] c, input logic [7:0] x, y, len,
                                      input logic [15:0] tag);
    logic [63:0] d;
    d = '0;
    d[63:50] = c;
    d[49:42] = x;
    d[41:34] = y;
    d[30:23] = len;
    d[15:0] = tag;
    return d;
  endfunction

  initial begin
    repeat (2) step();
    check("rst_valid", valid_out, 0);
    check("rst_yummy", yummy_out, 0);
    check("rst_rr", rr, 0);
    check("rst_tail", tail_out, 0);
    check("rst_err", protocol_err_out, 0);
    reset = 1'b0;
    // single-flit packet two hops east
    enq(hdr(3, 6, 4, 0, 16'h0011));
    check("t1_valid", valid_out, 1);
    check("t1_rr", rr, 5'b00010);
    check("t1_tail", tail_out, 1);
    check("t1_data", data_out, hdr(3, 6, 4, 0, 16'h0011));
    thanks_e_in = 1'b1;
    step();
    thanks_e_in = 1'b0;
    check("t1_yummy", yummy_out, 1);
    check("t1_empty", valid_out, 0);
    step();
    check("t1_yummy_off", yummy_out, 0);
    check("t1_err", protocol_err_out, 0);
    // three-flit packet to the local port
    enq(hdr(3, 4, 4, 2, 16'h0020));
    enq(64'hB0D1_0000_0000_0021);
    enq(64'hB0D1_0000_0000_0022);
    for (int i = 0; i < 3; i++) begin
      check("t2_rr", rr, 5'b10000);
      check("t2_tail", tail_out, i == 2);
      check("t2_data", data_out[15:0], 16'h0020 + 16'(i));
      thanks_p_in = 1'b1;
      step();
      thanks_p_in = 1'b0;
      check("t2_yummy", yummy_out, 1);
    end
    check("t2_empty", valid_out, 0);
    check("t2_rr_off", rr, 0);
    check("t2_err", protocol_err_out, 0);
    // overflow: fifth flit dropped
    for (int i = 0; i < 5; i++) enq(hdr(3, 4, 4, 0, 16'h0030 + 16'(i)));
    check("t3_err", protocol_err_out, 1);
    for (int i = 0; i < 4; i++) begin
      check("t3_data", data_out[15:0], 16'h0030 + 16'(i));
      thanks_p_in = 1'b1;
      step();
      thanks_p_in = 1'b0;
      check("t3_yummy", yummy_out, 1);
    end
    check("t3_dropped", valid_out, 0);
    check("t3_err_sticky", protocol_err_out, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t3_err_clr", protocol_err_out, 0);
    // full FIFO streaming with simultaneous enqueue and dequeue
    for (int i = 0; i < 4; i++) enq(hdr(3, 4, 4, 0, 16'h0040 + 16'(i)));
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1;
      data_in = hdr(3, 4, 4, 0, 16'h0044 + 16'(i));
      thanks_p_in = 1'b1;
      check("t4_data", data_out[15:0], 16'h0040 + 16'(i));
      step();
      check("t4_yummy", yummy_out, 1);
    end
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain", data_out[15:0], 16'h0054 + 16'(i));
      step();
    end
    thanks_p_in = 1'b0;
    check("t4_empty", valid_out, 0);
    check("t4_err", protocol_err_out, 0);
    // off-chip destination steers toward (0,0)
    my_loc_x_in = 8'd2;
    my_loc_y_in = 8'd3;
    enq(hdr(9, 5, 5, 0, 16'h0050));
    check("t5_w", rr, 5'b01000);
    my_loc_x_in = 8'd0;
    #1 check("t5_n", rr, 5'b00001);
    my_loc_y_in = 8'd0;
    #1 check("t5_p", rr, 5'b10000);
    thanks_p_in = 1'b1;
    step();
    thanks_p_in = 1'b0;
    check("t5_yummy", yummy_out, 1);
    my_loc_x_in = 8'd4;
    my_loc_y_in = 8'd4;
    // reset in the middle of a body
    enq(hdr(3, 6, 4, 3, 16'h0060));
    enq(64'hB0D1_0000_0000_0061);
    enq(64'hB0D1_0000_0000_0062);
    thanks_e_in = 1'b1;
    step();
    thanks_e_in = 1'b0;
    check("t6_yummy", yummy_out, 1);
    check("t6_body_rr", rr, 5'b00010);
    check("t6_body_tail", tail_out, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_valid", valid_out, 0);
    check("t6_no_yummy", yummy_out, 0);
    step();
    check("t6_no_yummy2", yummy_out, 0);
    enq(hdr(3, 4, 2, 0, 16'h0063));
    check("t6_new_rr", rr, 5'b00001);
    check("t6_new_tail", tail_out, 1);
    thanks_n_in = 1'b1;
    step();
    thanks_n_in = 1'b0;
    check("t6_new_yummy", yummy_out, 1);
    check("t6_err", protocol_err_out, 0);
    // thanks on the wrong direction still dequeues but flags an error
    enq(hdr(3, 4, 4, 0, 16'h0070));
    thanks_e_in = 1'b1;
    step();
    thanks_e_in = 1'b0;
    check("t7_yummy", yummy_out, 1);
    check("t7_valid", valid_out, 0);
    check("t7_err", protocol_err_out, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
